// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  // Number of write ports (writeback lanes); port 1 has priority over port 0.
  localparam int unsigned NUM_WR = 2;

  // Default register count of the integer file this slice is built for.
  localparam int unsigned DEFAULT_DEPTH = 32;

  // Address width needed to index a file of the given depth (minimum 1 bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Register index for the default-depth file.
  typedef logic [addr_w(DEFAULT_DEPTH)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Optional macro REGFILE_BYPASS_EN: a read hitting a same-cycle write sees the
// register as not busy unless the same cycle also issues to it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] wr_any;   // some accepted write targets this register
  logic [DEPTH-1:0] iss_hit;  // accepted issue targets this register

  // Decode accepted writes and issues per register; register 0 is immune when hardwired.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_any  = '0;
    iss_hit = '0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) wr_any[r] = 1'b1;
      end
      iss_hit[r] = iss_en_i && (iss_addr_i == AW'(r));
      if ((ZERO_REG != 0) && (r == 0)) begin
        wr_any[r]  = 1'b0;
        iss_hit[r] = 1'b0;
      end
    end
  end

  // Next busy state: issue beats writeback so a newer producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < int'(DEPTH); r++) begin
      if (iss_hit[r])     busy_d[r] = 1'b1;
      else if (wr_any[r]) busy_d[r] = 1'b0;
    end
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Per-port busy read mux, optional same-cycle forwarding, then zero-register masking.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wr_any[rd_addr_i[k*AW +: AW]]) begin
        rd_busy_o[k] = iss_en_i && (iss_addr_i == rd_addr_i[k*AW +: AW]);
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr_i[k*AW +: AW] == '0)) rd_busy_o[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes,
// optional hardwired-zero register 0 and an integrated busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: reads forward same-cycle write data
// (port 1 over port 0), giving zero write-to-read latency.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned DEPTH    = 32,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     iss_en_i,
  input  logic [AW-1:0]            iss_addr_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next data state: port 0 applied first, port 1 second so it wins on a shared address.
  always_comb begin
    for (int r = 0; r < int'(DEPTH); r++) begin
      mem_d[r] = mem_q[r];
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
          mem_d[r] = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (r == 0)) mem_d[r] = '0;
    end
  end

  // Data array with synchronous clear of every register.
  always_ff @(posedge clk) begin
    // NOTE: the whole array is reset because software relies on a zeroed file; this forces flops rather than a RAM macro.
    if (rst) begin
      for (int r = 0; r < int'(DEPTH); r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(DEPTH); r++) mem_q[r] <= mem_d[r];
    end
  end

  // Read muxes with optional write forwarding, zero-register masking last.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
          rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr_i[k*AW +: AW] == '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters (32 x 32, 2 read ports, zero register).
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned AW     = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after the edge, checks run 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input reg_idx_t a0, input reg_idx_t a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic check_port(input string tag, input int k, input logic [31:0] d, input logic b);
    check({tag, "_data"}, rd_data[k*DATA_W +: DATA_W], d);
    check({tag, "_busy"}, 32'(rd_busy[k]), 32'(b));
  endtask

  // Every register reads zero and not busy on both ports (port 1 scans in reverse).
  task automatic check_all_clear(input string tag);
    for (int r = 0; r < int'(DEPTH); r++) begin
      set_rd(reg_idx_t'(r), reg_idx_t'(DEPTH - 1 - r));
      check_port(tag, 0, 32'h0, 1'b0);
      check_port(tag, 1, 32'h0, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    tick();
    rst = 1'b0;

    // Reset state across the whole file.
    check_all_clear("reset");

    // Both write ports hit reg 5 in one cycle: port 1 wins.
    wr_en   = 2'b11;
    wr_addr = {reg_idx_t'(5), reg_idx_t'(5)};
    wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
    set_rd(5, 5);
`ifdef REGFILE_BYPASS_EN
    check_port("r5_same_cycle", 0, 32'h1234_5678, 1'b0);
`else
    check_port("r5_same_cycle", 0, 32'h0, 1'b0);
`endif
    tick();
    idle();
    set_rd(5, 5);
    check_port("r5_prio_p0", 0, 32'h1234_5678, 1'b0);
    check_port("r5_prio_p1", 1, 32'h1234_5678, 1'b0);

    // Hardwired zero: write and issue to reg 0 are dropped.
    wr_en    = 2'b01;
    wr_addr  = {reg_idx_t'(0), reg_idx_t'(0)};
    wr_data  = {32'h0, 32'hFFFF_FFFF};
    iss_en   = 1'b1;
    iss_addr = 0;
    set_rd(0, 0);
    check_port("r0_same_cycle", 0, 32'h0, 1'b0);
    tick();
    idle();
    set_rd(0, 0);
    check_port("r0_zero_p0", 0, 32'h0, 1'b0);
    check_port("r0_zero_p1", 1, 32'h0, 1'b0);

    // Issue reg 7: busy next cycle, data still old.
    iss_en   = 1'b1;
    iss_addr = 7;
    set_rd(7, 5);
    check_port("r7_pre_issue", 0, 32'h0, 1'b0);
    tick();
    idle();
    set_rd(7, 5);
    check_port("r7_issued", 0, 32'h0, 1'b1);
    check_port("r5_indep", 1, 32'h1234_5678, 1'b0);

    // Writeback to reg 7 clears busy at the edge.
    wr_en   = 2'b01;
    wr_addr = {reg_idx_t'(0), reg_idx_t'(7)};
    wr_data = {32'h0, 32'h0000_00A5};
    set_rd(7, 7);
`ifdef REGFILE_BYPASS_EN
    check_port("r7_wb_same_cycle", 0, 32'h0000_00A5, 1'b0);
`else
    check_port("r7_wb_same_cycle", 0, 32'h0, 1'b1);
`endif
    tick();
    idle();
    set_rd(7, 7);
    check_port("r7_written", 0, 32'h0000_00A5, 1'b0);

    // Issue and write reg 7 together: data written, busy stays set.
    wr_en    = 2'b10;
    wr_addr  = {reg_idx_t'(7), reg_idx_t'(0)};
    wr_data  = {32'h0000_0077, 32'h0};
    iss_en   = 1'b1;
    iss_addr = 7;
    set_rd(7, 7);
`ifdef REGFILE_BYPASS_EN
    check_port("r7_iss_wb_same_cycle", 1, 32'h0000_0077, 1'b1);
`else
    check_port("r7_iss_wb_same_cycle", 1, 32'h0000_00A5, 1'b0);
`endif
    tick();
    idle();
    set_rd(7, 7);
    check_port("r7_iss_wb", 1, 32'h0000_0077, 1'b1);

    // Write-to-read latency on reg 3 (old value 0x11, new value 0x55).
    wr_en   = 2'b01;
    wr_addr = {reg_idx_t'(0), reg_idx_t'(3)};
    wr_data = {32'h0, 32'h0000_0011};
    tick();
    wr_en   = 2'b10;
    wr_addr = {reg_idx_t'(3), reg_idx_t'(0)};
    wr_data = {32'h0000_0055, 32'h0};
    set_rd(3, 7);
`ifdef REGFILE_BYPASS_EN
    check_port("r3_same_cycle", 0, 32'h0000_0055, 1'b0);
`else
    check_port("r3_same_cycle", 0, 32'h0000_0011, 1'b0);
`endif
    tick();
    idle();
    set_rd(3, 7);
    check_port("r3_next_cycle", 0, 32'h0000_0055, 1'b0);
    check_port("r7_still_busy", 1, 32'h0000_0077, 1'b1);

    // Reset overrides concurrent writes and issue.
    rst      = 1'b1;
    wr_en    = 2'b11;
    wr_addr  = {reg_idx_t'(10), reg_idx_t'(9)};
    wr_data  = {32'hCAFE_F00D, 32'hBEEF_0001};
    iss_en   = 1'b1;
    iss_addr = 12;
    tick();
    rst = 1'b0;
    idle();
    check_all_clear("rst_override");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
